// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a valid/ready handshake and an IDLE/WAIT/OUT sequencer.
// Define ALU_CTRL_MUL_EN to decode MUL (funct7=0000001) with a MUL_CYCLES latency.
module alu_ctrl_seq #(
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic [1:0] ALUOp_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [2:0] ALUCtrl_o,
   output logic       illegal_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      OUT  = 2'b10
   } state_e;

   localparam logic [2:0] CtrlAnd  = 3'b000;
   localparam logic [2:0] CtrlXor  = 3'b001;
   localparam logic [2:0] CtrlSll  = 3'b010;
   localparam logic [2:0] CtrlAdd  = 3'b011;
   localparam logic [2:0] CtrlSub  = 3'b100;
   localparam logic [2:0] CtrlSlt  = 3'b110;
   localparam logic [2:0] CtrlSrai = 3'b111;
   localparam bit MulSingleCycle   = (MUL_CYCLES <= 1);

   state_e     state_q, state_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic       illegal_q, illegal_d;
   logic [2:0] decCtrl;
   logic       decIllegal;
   logic       decMul;
   logic       accept;
   logic       waitDone;

   // Instruction decode; anything not listed falls through to illegal/ADD.
   always_comb begin
      decCtrl    = CtrlAdd;
      decIllegal = 1'b1;
      decMul     = 1'b0;
      case (ALUOp_i)
         2'b00: begin
            decCtrl    = CtrlAdd;
            decIllegal = 1'b0;
         end
         2'b01: begin
            decCtrl    = CtrlSub;
            decIllegal = 1'b0;
         end
         2'b10: begin
            if (funct7_i == 7'b0000000) begin
               case (funct3_i)
                  3'b111: begin decCtrl = CtrlAnd; decIllegal = 1'b0; end
                  3'b100: begin decCtrl = CtrlXor; decIllegal = 1'b0; end
                  3'b001: begin decCtrl = CtrlSll; decIllegal = 1'b0; end
                  3'b000: begin decCtrl = CtrlAdd; decIllegal = 1'b0; end
                  3'b010: begin decCtrl = CtrlSlt; decIllegal = 1'b0; end
                  default: ;
               endcase
            end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
               decCtrl    = CtrlSub;
               decIllegal = 1'b0;
            end
`ifdef ALU_CTRL_MUL_EN
            else if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
               decCtrl    = 3'b101;
               decIllegal = 1'b0;
               decMul     = 1'b1;
            end
`endif
         end
         default: begin
            if (funct3_i == 3'b000) begin
               decCtrl    = CtrlAdd;
               decIllegal = 1'b0;
            end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
               decCtrl    = CtrlSrai;
               decIllegal = 1'b0;
            end
         end
      endcase
   end

   assign accept = valid_i && ready_o;

`ifdef ALU_CTRL_MUL_EN
   localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

   logic [3:0] cnt_q, cnt_d;

   // Counts down the remaining MUL latency; OUT is entered when it reaches 1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept && decMul && !MulSingleCycle) begin
         cnt_d = MulLoad;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   assign waitDone = (cnt_q == 4'd1);
`else
   assign waitDone = 1'b1;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ctrl_q    <= 3'b000;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   // Next state: OUT can retire and accept on the same edge without a bubble.
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      if (accept) begin
         ctrl_d    = decCtrl;
         illegal_d = decIllegal;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (decMul && !MulSingleCycle) ? WAIT : OUT;
            end
         end
         WAIT: begin
            if (waitDone) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (accept) begin
               state_d = (decMul && !MulSingleCycle) ? WAIT : OUT;
            end else if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o   = (state_q == IDLE) || ((state_q == OUT) && ready_i);
      valid_o   = (state_q == OUT);
      ALUCtrl_o = ctrl_q;
      illegal_o = illegal_q;
   end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL provide parameter MUL_CYCLES, default 3, giving cycles from MUL acceptance to valid_o (legal range 1..15).
REQ-002 SHALL provide clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide valid_i  input  1  upstream decode request valid.
REQ-005 SHALL provide ready_o  output  1  block can accept a request this cycle.
REQ-006 SHALL provide ALUOp_i  input  2  op class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 SHALL provide funct7_i  input  7  instruction funct7 field.
REQ-008 SHALL provide funct3_i  input  3  instruction funct3 field.
REQ-009 SHALL provide valid_o  output  1  ALUCtrl_o and illegal_o are valid.
REQ-010 SHALL provide ready_i  input  1  downstream ALU/writeback consumes the result.
REQ-011 SHALL provide ALUCtrl_o  output  3  ALU operation code.
REQ-012 SHALL provide illegal_o  output  1  request did not decode to a supported operation.

Function
REQ-013 SHALL encode ALUCtrl_o as AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, SLT=110, SRAI=111.
REQ-014 SHALL decode ALUOp 00 -> ADD and ALUOp 01 -> SUB, ignoring funct fields.
REQ-015 SHALL decode ALUOp 10 with funct7=0000000: funct3 111 AND, 100 XOR, 001 SLL, 000 ADD, 010 SLT; with funct7=0100000, funct3 000: SUB; with funct7=0000001, funct3 000: MUL.
REQ-016 SHALL decode ALUOp 11: funct3 000 -> ADD (funct7 ignored); funct3 101 with funct7=0100000 -> SRAI.
REQ-017 SHALL set illegal_o=1 and ALUCtrl_o=ADD for every other combination.
REQ-018 SHALL implement states IDLE, WAIT, OUT; ready_o = (IDLE) or (OUT and ready_i); WAIT never accepts.
REQ-019 SHALL accept a request only on a cycle where valid_i and ready_o are both 1, latching decoded outputs on that edge.
REQ-020 SHALL, for non-MUL requests (or MUL with MUL_CYCLES=1), enter OUT on the accept edge, giving valid_o one cycle after acceptance.
REQ-021 SHALL, for MUL with MUL_CYCLES>1, enter WAIT with a 4-bit counter loaded to MUL_CYCLES-1, decrement each cycle, and move to OUT when the counter reaches 1, so valid_o rises exactly MUL_CYCLES cycles after acceptance.
REQ-022 SHALL drive valid_o=1 only in OUT and hold ALUCtrl_o/illegal_o stable while valid_o=1 and ready_i=0.
REQ-023 SHALL, in OUT with ready_i=1 and valid_i=0, return to IDLE and clear valid_o next cycle.
REQ-024 SHALL, in OUT with ready_i=1 and valid_i=1, retire and accept on the same edge (back-to-back, no bubble for non-MUL).
REQ-025 SHALL ignore funct/ALUOp changes while in WAIT or while holding in OUT.

Reset
REQ-026 SHALL, on rst_i assertion at any time including mid-WAIT, immediately force state IDLE, counter 0, valid_o 0, ALUCtrl_o 000, illegal_o 0, and drop the in-flight request.
REQ-027 SHALL drive ready_o=1 from the first rising clock edge after rst_i deasserts.

Configuration
REQ-028 SHALL, with macro ALU_CTRL_MUL_EN defined, decode MUL per REQ-015 and REQ-021.
REQ-029 SHALL, with ALU_CTRL_MUL_EN undefined, treat funct7=0000001 as illegal (ALUCtrl_o=ADD, illegal_o=1, latency 1), never enter WAIT, and omit the counter logic.

Verification
REQ-030 SHALL cover: reset, then R-type funct7=0000000 funct3=111 with ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=000, illegal_o=0.
REQ-031 SHALL cover: MUL (ALUOp 10, funct7 0000001, funct3 000), MUL_CYCLES=3, macro on -> ready_o=0 for 2 cycles, valid_o=1 with ALUCtrl_o=101 at accept+3.
REQ-032 SHALL cover: ALUOp 11 funct3 101 funct7 0100000 with ready_i=0 for 4 cycles -> ALUCtrl_o=111 held stable, ready_o=0; retires when ready_i=1.
REQ-033 SHALL cover: back-to-back ADD then SUB with valid_i, ready_i high -> ALUCtrl_o 011 then 100 on consecutive cycles, no bubble.
REQ-034 SHALL cover: rst_i pulsed mid-WAIT -> valid_o=0, ALUCtrl_o=000 immediately; ALUOp 10 funct3 011 -> illegal_o=1, ALUCtrl_o=011.
REQ-035 SHALL cover: macro off, MUL request -> valid_o at accept+1, illegal_o=1, ALUCtrl_o=011.
